// File: rtl/arbitro_mux2.sv
// Two-requester round-robin arbiter in front of a 2:1 word mux.
// The winner's word is registered onto saida, and each grant is bounded to MAX_RAJADA transfers while the other side waits.

module Mux2_1 #(
    parameter int LARGURA = 32
) (
    input  logic [LARGURA-1:0] A,
    input  logic [LARGURA-1:0] B,
    input  logic               controle,
    output logic [LARGURA-1:0] saida
);
    always_comb begin
        saida = controle ? B : A;
    end
endmodule

module arbitro_mux2 #(
    parameter int LARGURA    = 32,
    parameter int MAX_RAJADA = 4
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic               reqA,
    input  logic [LARGURA-1:0] dadoA,
    input  logic               reqB,
    input  logic [LARGURA-1:0] dadoB,
    output logic               gntA,
    output logic               gntB,
    output logic               controle,
    output logic [LARGURA-1:0] saida,
    output logic               saida_valida,
    output logic               ocupado
);
    typedef enum logic [1:0] {OCIOSO, CONCEDE_A, CONCEDE_B} estado_t;

    estado_t            estado;
    estado_t            estadoProx;
    logic               ultimoB;
    logic [7:0]         contador;
    logic [LARGURA-1:0] muxSaida;
    logic               transfere;
    logic               fimRajada;

    Mux2_1 #(.LARGURA(LARGURA)) uMux (
        .A        (dadoA),
        .B        (dadoB),
        .controle (controle),
        .saida    (muxSaida)
    );

    // The edge that completes the burst transfers its word and hands over in one step.
    always_comb begin
        transfere  = ((estado == CONCEDE_A) && reqA) || ((estado == CONCEDE_B) && reqB);
        fimRajada  = (9'(contador) + 9'd1) >= 9'(MAX_RAJADA);
        estadoProx = estado;
        case (estado)
            OCIOSO: begin
                if (reqA && (!reqB || ultimoB))
                    estadoProx = CONCEDE_A;
                else if (reqB)
                    estadoProx = CONCEDE_B;
            end
            CONCEDE_A: begin
                if (!reqA)
                    estadoProx = reqB ? CONCEDE_B : OCIOSO;
                else if (reqB && fimRajada)
                    estadoProx = CONCEDE_B;
            end
            CONCEDE_B: begin
                if (!reqB)
                    estadoProx = reqA ? CONCEDE_A : OCIOSO;
                else if (reqA && fimRajada)
                    estadoProx = CONCEDE_A;
            end
            default: estadoProx = OCIOSO;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            estado       <= OCIOSO;
            gntA         <= 1'b0;
            gntB         <= 1'b0;
            controle     <= 1'b0;
            ocupado      <= 1'b0;
            saida        <= '0;
            saida_valida <= 1'b0;
            contador     <= '0;
            ultimoB      <= 1'b1;
        end else begin
            estado       <= estadoProx;
            gntA         <= (estadoProx == CONCEDE_A);
            gntB         <= (estadoProx == CONCEDE_B);
            ocupado      <= (estadoProx != OCIOSO);
            saida_valida <= transfere;
            if (estadoProx == CONCEDE_A)
                controle <= 1'b0;
            else if (estadoProx == CONCEDE_B)
                controle <= 1'b1;
            if (transfere) begin
                saida   <= muxSaida;
                ultimoB <= (estado == CONCEDE_B);
            end
            if (estadoProx != estado)
                contador <= '0;
            else if (transfere && (contador < 8'(MAX_RAJADA)))
                contador <= contador + 8'd1;
        end
    end
endmodule

// File: tb/tb_arbitro_mux2.sv
// Bench for arbitro_mux2: directed scenarios with literal expectations, then randomized
// request/data/reset traffic compared every cycle against an owner/turn model.

module tb_arbitro_mux2;
    localparam int LARG = 32;
    localparam int MAXR = 4;

    logic            Clock = 1'b0;
    logic            Reset_n;
    logic            reqA, reqB;
    logic [LARG-1:0] dadoA, dadoB;
    logic            gntA, gntB, controle, saida_valida, ocupado;
    logic [LARG-1:0] saida;

    int nComp = 0;
    int nFail = 0;

    arbitro_mux2 #(.LARGURA(LARG), .MAX_RAJADA(MAXR)) dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .reqA         (reqA),
        .dadoA        (dadoA),
        .reqB         (reqB),
        .dadoB        (dadoB),
        .gntA         (gntA),
        .gntB         (gntB),
        .controle     (controle),
        .saida        (saida),
        .saida_valida (saida_valida),
        .ocupado      (ocupado)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        nComp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s at %0t: got %h, expected %h", nome, $time, act, exp);
        end
    endtask

    // Model: who owns the datapath (0 none, 1 A, 2 B), who was served last,
    // and how many words the current owner has moved.
    int              mOwner, mLast, mCnt;
    logic [LARG-1:0] mSaida;
    logic            mValid, mCtl;

    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            mOwner = 0; mLast = 2; mCnt = 0;
            mSaida = '0; mValid = 1'b0; mCtl = 1'b0;
        end else begin
            int  other;
            bit  wantOwn, wantOther;
            wantOwn   = (mOwner == 1) ? reqA : (mOwner == 2) ? reqB : 1'b0;
            other     = (mOwner == 1) ? 2 : 1;
            wantOther = (other == 1) ? reqA : reqB;
            mValid    = (mOwner != 0) && wantOwn;
            if (mValid) begin
                mSaida = (mOwner == 1) ? dadoA : dadoB;
                mLast  = mOwner;
            end
            if (mOwner == 0) begin
                if (reqA && reqB)  begin mOwner = (mLast == 1) ? 2 : 1; mCnt = 0; end
                else if (reqA)     begin mOwner = 1; mCnt = 0; end
                else if (reqB)     begin mOwner = 2; mCnt = 0; end
            end else if (!wantOwn) begin
                mOwner = wantOther ? other : 0;
                mCnt   = 0;
            end else if (wantOther && (mCnt + 1 >= MAXR)) begin
                mOwner = other;
                mCnt   = 0;
            end else begin
                mCnt = (mCnt + 1 > MAXR) ? MAXR : mCnt + 1;
            end
            if (mOwner == 1) mCtl = 1'b0;
            else if (mOwner == 2) mCtl = 1'b1;
        end
    end

    always @(negedge Clock) begin
        chk("gntA",         32'(gntA),         32'(mOwner == 1));
        chk("gntB",         32'(gntB),         32'(mOwner == 2));
        chk("ocupado",      32'(ocupado),      32'(mOwner != 0));
        chk("controle",     32'(controle),     32'(mCtl));
        chk("saida_valida", 32'(saida_valida), 32'(mValid));
        chk("saida",        saida,             mSaida);
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Called at edge+1: 3 ns low pulse, released well before the next edge.
    task automatic pulseReset();
        Reset_n = 1'b0;
        #3;
        Reset_n = 1'b1;
    endtask

    initial begin
        Reset_n = 1'b0;
        reqA = 1'b0; reqB = 1'b0; dadoA = '0; dadoB = '0;
        #12;
        Reset_n = 1'b1;
        chk("rst_gntA", 32'(gntA), 32'd0);
        chk("rst_gntB", 32'(gntB), 32'd0);
        chk("rst_saida", saida, 32'd0);
        chk("rst_valid", 32'(saida_valida), 32'd0);
        chk("rst_ocupado", 32'(ocupado), 32'd0);

        // A alone
        reqA = 1'b1; dadoA = 32'hA5A5_0001;
        step();
        chk("a_gntA", 32'(gntA), 32'd1);
        chk("a_ctl", 32'(controle), 32'd0);
        chk("a_valid0", 32'(saida_valida), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("a_saida", saida, 32'hA5A5_0001);
            chk("a_valid", 32'(saida_valida), 32'd1);
            chk("a_gntB", 32'(gntB), 32'd0);
        end
        reqA = 1'b0;
        step();
        chk("a_idle_ocup", 32'(ocupado), 32'd0);
        chk("a_idle_hold", saida, 32'hA5A5_0001);

        // A served last, so a tie goes to B; then bursts of MAXR alternate
        reqA = 1'b1; reqB = 1'b1; dadoA = 32'd1; dadoB = 32'd2;
        step();
        chk("tie_gntB", 32'(gntB), 32'd1);
        chk("tie_ctl", 32'(controle), 32'd1);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("rr_saida", saida, (((k - 1) / MAXR) % 2 == 0) ? 32'd2 : 32'd1);
            chk("rr_valid", 32'(saida_valida), 32'd1);
        end

        // B alone, then B drops
        reqA = 1'b0; dadoB = 32'hFFFF_FFFF;
        step();
        chk("b_gntB", 32'(gntB), 32'd1);
        chk("b_ctl", 32'(controle), 32'd1);
        step();
        chk("b_saida", saida, 32'hFFFF_FFFF);
        reqB = 1'b0;
        step();
        chk("b_idle_valid", 32'(saida_valida), 32'd0);
        chk("b_idle_hold", saida, 32'hFFFF_FFFF);
        chk("b_idle_ocup", 32'(ocupado), 32'd0);
        chk("b_idle_ctl", 32'(controle), 32'd1);

        // asynchronous reset in the middle of a B burst
        reqB = 1'b1;
        step();
        step();
        #1;
        Reset_n = 1'b0;
        #1;
        chk("ar_gntB", 32'(gntB), 32'd0);
        chk("ar_ctl", 32'(controle), 32'd0);
        chk("ar_saida", saida, 32'd0);
        chk("ar_valid", 32'(saida_valida), 32'd0);
        #2;
        Reset_n = 1'b1;
        step();
        chk("ar_resume_gntB", 32'(gntB), 32'd1);
        chk("ar_resume_valid", 32'(saida_valida), 32'd0);

        // after reset B is "last", so A wins the tie
        reqA = 1'b1;
        pulseReset();
        step();
        chk("rst_tie_gntA", 32'(gntA), 32'd1);

        // saturated counter: one more A word once B asks, then B
        reqB = 1'b0;
        pulseReset();
        step();
        for (int i = 0; i < 10; i++) begin
            dadoA = 32'h100 + 32'(i);
            step();
            chk("sat_a", saida, 32'h100 + 32'(i));
        end
        reqB = 1'b1; dadoA = 32'h1FF; dadoB = 32'hBBBB;
        step();
        chk("sat_last_a", saida, 32'h1FF);
        chk("sat_gntB", 32'(gntB), 32'd1);
        step();
        chk("sat_first_b", saida, 32'hBBBB);
        chk("sat_valid", 32'(saida_valida), 32'd1);

        // random traffic, occasional reset pulses
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) reqA = ~reqA;
            if ($urandom_range(7) == 0) reqB = ~reqB;
            dadoA = $urandom;
            dadoB = $urandom;
            if ($urandom_range(399) == 0) pulseReset();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
        $finish;
    end
endmodule
